// File: rtl/divider_pkg.sv
// ----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential divider:
//   state_t            - FSM encoding (IDLE / RUN / FINISH)
//   DIV_WIDTH          - default operand width
//   DIV_ZERO_FILL      - fill bit of the divide-by-zero quotient (all ones)
// ----------------------------------------------------------------------------
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int DIV_WIDTH = 32;

   // A divide by zero reports a quotient of all ones at any width, so the
   // constant is kept as a fill bit and replicated to WIDTH by the user.
   localparam logic DIV_ZERO_FILL = 1'b1;

endpackage

// File: rtl/divider_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring shift-subtract iteration.
// Ports:
//   rem_in  [WIDTH:0]   partial remainder before this step
//   dvs     [WIDTH-1:0] divisor
//   q_msb               quotient/dividend bit shifted into the remainder
//   rem_out [WIDTH:0]   partial remainder after this step
//   q_bit               quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] dvs,
   input  logic             q_msb,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The extra top bit keeps the trial subtraction from overflowing even
   // when the divisor is all ones and the shifted remainder exceeds WIDTH bits.
   assign shifted = {rem_in[WIDTH-1:0], q_msb};
   assign diff    = shifted - {1'b0, dvs};
   assign q_bit   = (shifted >= {1'b0, dvs});
   assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/divider.sv
// ----------------------------------------------------------------------------
// divider
// Sequential unsigned divider, restoring algorithm, one quotient bit per clock.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request a divide (honoured only while busy=0)
//   dividend, divisor     operands, sampled with start
//   busy                  divide in progress (RUN or FINISH)
//   done                  one-cycle pulse, results valid
//   quotient, remainder   result of the last completed divide (held)
//   div_zero              last completed divide had divisor==0
// ----------------------------------------------------------------------------
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] dvs_reg, dvs_next;
   logic [WIDTH:0]   rem_reg, rem_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] quotient_reg, quotient_next;
   logic [WIDTH-1:0] remainder_reg, remainder_next;
   logic             div_zero_reg, div_zero_next;
   logic             done_reg, done_next;

   logic [WIDTH:0]   step_rem;
   logic             step_bit;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_reg),
      .dvs     (dvs_reg),
      .q_msb   (q_reg[WIDTH-1]),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         q_reg         <= '0;
         dvs_reg       <= '0;
         rem_reg       <= '0;
         count_reg     <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         div_zero_reg  <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         q_reg         <= q_next;
         dvs_reg       <= dvs_next;
         rem_reg       <= rem_next;
         count_reg     <= count_next;
         quotient_reg  <= quotient_next;
         remainder_reg <= remainder_next;
         div_zero_reg  <= div_zero_next;
         done_reg      <= done_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      q_next         = q_reg;
      dvs_next       = dvs_reg;
      rem_next       = rem_reg;
      count_next     = count_reg;
      quotient_next  = quotient_reg;
      remainder_next = remainder_reg;
      div_zero_next  = div_zero_reg;
      done_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               dvs_next   = divisor;
               count_next = CW'(WIDTH);
               if (divisor == '0) begin
                  // Divide by zero: preload the final answer so FINISH can
                  // publish it exactly like a computed result.
                  q_next     = {WIDTH{DIV_ZERO_FILL}};
                  rem_next   = {1'b0, dividend};
                  state_next = FINISH;
               end else begin
                  q_next     = dividend;
                  rem_next   = '0;
                  state_next = RUN;
               end
            end
         end

         RUN: begin
            // q_reg holds the not-yet-consumed dividend bits in its upper part
            // and the quotient bits produced so far in its lower part.
            rem_next   = step_rem;
            q_next     = {q_reg[WIDTH-2:0], step_bit};
            count_next = count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
               state_next = FINISH;
            end
         end

         FINISH: begin
            // The visible results (including div_zero) change only here, so
            // the previous result stays readable while a new divide runs.
            quotient_next  = q_reg;
            remainder_next = rem_reg[WIDTH-1:0];
            div_zero_next  = (dvs_reg == '0);
            done_next      = 1'b1;
            state_next     = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign quotient  = quotient_reg;
   assign remainder = remainder_reg;
   assign div_zero  = div_zero_reg;

endmodule
